// File: rtl/sys6502_top.sv
// 6502 system: core, RAM/ROM subsystem, address decode and read/write bus muxing.
// core6502 here is a compact multi-cycle core: LDA #/abs, STA abs, JMP abs; other opcodes act as NOP.

module core6502 (
   input  logic        clk,
   input  logic        reset,
   output logic [15:0] addr,
   input  logic [7:0]  data_in,
   output logic [7:0]  data_out,
   output logic        we
);
   typedef enum logic [2:0] {S_VEC_LO, S_VEC_HI, S_FETCH, S_OP1, S_OP2, S_EXEC} state_t;

   localparam logic [7:0] OP_LDA_IMM = 8'hA9;
   localparam logic [7:0] OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_STA_ABS = 8'h8D;
   localparam logic [7:0] OP_JMP_ABS = 8'h4C;

   state_t      r_state, w_state_nxt;
   logic [15:0] r_pc, w_pc_nxt;
   logic [7:0]  r_ir, w_ir_nxt;
   logic [7:0]  r_lo, w_lo_nxt;
   logic [7:0]  r_hi, w_hi_nxt;
   logic [7:0]  r_a, w_a_nxt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_VEC_LO;
         r_pc    <= '0;
         r_ir    <= '0;
         r_lo    <= '0;
         r_hi    <= '0;
         r_a     <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         r_lo    <= w_lo_nxt;
         r_hi    <= w_hi_nxt;
         r_a     <= w_a_nxt;
      end
   end

   // Bus outputs depend on state only, keeping the address -> read-data path acyclic.
   always_comb begin
      addr     = r_pc;
      data_out = r_a;
      we       = 1'b0;
      unique case (r_state)
         S_VEC_LO: addr = 16'hFFFC;
         S_VEC_HI: addr = 16'hFFFD;
         S_EXEC: begin
            addr = {r_hi, r_lo};
            we   = (r_ir == OP_STA_ABS);
         end
         default: ;
      endcase
   end

   // NOTE: every variable gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_lo_nxt    = r_lo;
      w_hi_nxt    = r_hi;
      w_a_nxt     = r_a;
      unique case (r_state)
         S_VEC_LO: begin
            w_pc_nxt[7:0] = data_in;
            w_state_nxt   = S_VEC_HI;
         end
         S_VEC_HI: begin
            w_pc_nxt[15:8] = data_in;
            w_state_nxt    = S_FETCH;
         end
         S_FETCH: begin
            w_ir_nxt = data_in;
            w_pc_nxt = r_pc + 16'd1;
            case (data_in)
               OP_LDA_IMM, OP_LDA_ABS, OP_STA_ABS, OP_JMP_ABS: w_state_nxt = S_OP1;
               default:                                        w_state_nxt = S_FETCH;
            endcase
         end
         S_OP1: begin
            w_pc_nxt = r_pc + 16'd1;
            if (r_ir == OP_LDA_IMM) begin
               w_a_nxt     = data_in;
               w_state_nxt = S_FETCH;
            end else begin
               w_lo_nxt    = data_in;
               w_state_nxt = S_OP2;
            end
         end
         S_OP2: begin
            w_hi_nxt = data_in;
            if (r_ir == OP_JMP_ABS) begin
               w_pc_nxt    = {data_in, r_lo};
               w_state_nxt = S_FETCH;
            end else begin
               w_pc_nxt    = r_pc + 16'd1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            if (r_ir == OP_LDA_ABS) w_a_nxt = data_in;
            w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_VEC_LO;
      endcase
   end
endmodule

module sys6502_mem #(
   parameter int RAM_WORDS = 2048,
   parameter int ROM_WORDS = 4096,
   parameter int RAM_AW    = $clog2(RAM_WORDS),
   parameter int ROM_AW    = $clog2(ROM_WORDS)
) (
   input  logic              i_clk,
   input  logic              i_ram_we,
   input  logic [RAM_AW-1:0] i_ram_idx,
   input  logic [7:0]        i_ram_wdata,
   input  logic [ROM_AW-1:0] i_rom_idx,
   output logic [7:0]        o_ram_rdata,
   output logic [7:0]        o_rom_rdata
);
   // Plain arrays so benches can preload and inspect them hierarchically; ROM is loaded only that way.
   reg [7:0] RAM [0:RAM_WORDS-1];
   reg [7:0] ROM [0:ROM_WORDS-1];

   // NOTE: memory arrays take no reset; contents survive reset and are never cleared by hardware.
   always_ff @(posedge i_clk) begin
      if (i_ram_we) RAM[i_ram_idx] <= i_ram_wdata;
   end

   assign o_ram_rdata = RAM[i_ram_idx];
   assign o_rom_rdata = ROM[i_rom_idx];
endmodule

module sys6502_top #(
   parameter int RAM_WORDS = 2048,
   parameter int ROM_WORDS = 4096
) (
   input logic ph1,
   input logic reset
);
   localparam int RAM_AW   = $clog2(RAM_WORDS);
   localparam int ROM_AW   = $clog2(ROM_WORDS);
   localparam int ROM_BASE = 32'h1_0000 - ROM_WORDS;

   logic [15:0]       w_addr;
   logic [7:0]        w_data_in, w_data_out;
   logic [7:0]        w_ram_rdata, w_rom_rdata;
   logic              w_core_we, w_ram_sel, w_rom_sel, w_ram_we;
   logic [RAM_AW-1:0] w_ram_idx;
   logic [ROM_AW-1:0] w_rom_idx;

   core6502 core (
      .clk      (ph1),
      .reset    (reset),
      .addr     (w_addr),
      .data_in  (w_data_in),
      .data_out (w_data_out),
      .we       (w_core_we)
   );

   assign w_ram_sel = 32'(w_addr) < RAM_WORDS;
   assign w_rom_sel = 32'(w_addr) >= ROM_BASE;
   assign w_ram_idx = RAM_AW'(w_addr);
   assign w_rom_idx = ROM_AW'(w_addr - 16'(ROM_BASE));
   // A store issued in the same cycle reset is high must not reach RAM.
   assign w_ram_we  = w_core_we & w_ram_sel & ~reset;

   sys6502_mem #(.RAM_WORDS(RAM_WORDS), .ROM_WORDS(ROM_WORDS)) mem (
      .i_clk       (ph1),
      .i_ram_we    (w_ram_we),
      .i_ram_idx   (w_ram_idx),
      .i_ram_wdata (w_data_out),
      .i_rom_idx   (w_rom_idx),
      .o_ram_rdata (w_ram_rdata),
      .o_rom_rdata (w_rom_rdata)
   );

   assign w_data_in = w_ram_sel ? w_ram_rdata :
                      w_rom_sel ? w_rom_rdata : 8'h00;
endmodule

// File: tb/tb_sys6502_top.sv
// Directed bench for sys6502_top: vector fetch, RAM/ROM access, decode boundaries, reset during a store.
// Expected bus writes go into a scoreboard queue; a monitor pops and compares them as the core issues them.

module tb_sys6502_top;
   logic ph1   = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t        exp_wr_q[$];
   wr_t        mon_e;
   logic [7:0] prog[$];
   logic [7:0] ram_snap [0:2047];
   logic [7:0] rom_snap [0:4095];
   int         n_diff;
   logic       found;

   sys6502_top #(.RAM_WORDS(2048), .ROM_WORDS(4096)) dut (
      .ph1   (ph1),
      .reset (reset)
   );

   always #5 ph1 = ~ph1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load_rom(input int base);
      foreach (prog[i]) dut.mem.ROM[base + i] = prog[i];
   endtask

   task automatic apply_reset(input int n);
      @(negedge ph1);
      reset = 1'b1;
      repeat (n) @(negedge ph1);
      reset = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge ph1);
      #1;
   endtask

   // Write monitor: samples the core bus just after each falling edge.
   always begin
      @(negedge ph1);
      #2;
      if (dut.w_core_we && !reset) begin
         check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
         if (exp_wr_q.size() != 0) begin
            mon_e = exp_wr_q.pop_front();
            check("wr_addr", 32'(dut.w_addr), 32'(mon_e.addr));
            check("wr_data", 32'(dut.w_data_out), 32'(mon_e.data));
         end
      end
   end

   initial begin
      // Reset vector fetch
      dut.mem.ROM[4092] = 8'h00;
      dut.mem.ROM[4093] = 8'hF0;
      for (int i = 0; i < 8; i++) dut.mem.ROM[i] = 8'hEA;
      apply_reset(5);
      #1;
      check("vec_addr0", 32'(dut.w_addr), 32'hFFFC);
      run(1); check("vec_addr1", 32'(dut.w_addr), 32'hFFFD);
      run(1); check("vec_addr2", 32'(dut.w_addr), 32'hF000);
      run(1); check("vec_addr3", 32'(dut.w_addr), 32'hF001);

      // RAM store/load: LDA #5A; STA 0210; LDA #0; LDA 0210; STA 0211; JMP *
      reset = 1'b1;
      prog = '{8'hA9, 8'h5A, 8'h8D, 8'h10, 8'h02, 8'hA9, 8'h00, 8'hAD, 8'h10, 8'h02,
               8'h8D, 8'h11, 8'h02, 8'h4C, 8'h0D, 8'hF0};
      load_rom(0);
      dut.mem.RAM[16'h210] = 8'h00;
      dut.mem.RAM[16'h211] = 8'h00;
      exp_wr_q.push_back('{16'h0210, 8'h5A});
      exp_wr_q.push_back('{16'h0211, 8'h5A});
      apply_reset(2);
      run(40);
      check("ram_store", 32'(dut.mem.RAM[528]), 32'h5A);
      check("ram_reload", 32'(dut.mem.RAM[529]), 32'h5A);
      check("acc_reload", 32'(dut.core.r_a), 32'h5A);
      check("wrq_empty_ram", 32'(exp_wr_q.size()), 32'd0);

      // ROM write protection: LDA #77; STA F010; LDA F010; STA 0220; JMP *
      reset = 1'b1;
      dut.mem.ROM[16] = 8'h11;
      prog = '{8'hA9, 8'h77, 8'h8D, 8'h10, 8'hF0, 8'hAD, 8'h10, 8'hF0,
               8'h8D, 8'h20, 8'h02, 8'h4C, 8'h0B, 8'hF0};
      load_rom(0);
      dut.mem.RAM[16'h220] = 8'h00;
      exp_wr_q.push_back('{16'hF010, 8'h77});
      exp_wr_q.push_back('{16'h0220, 8'h11});
      apply_reset(2);
      run(40);
      check("rom_protect", 32'(dut.mem.ROM[16]), 32'h11);
      check("rom_readback", 32'(dut.mem.RAM[16'h220]), 32'h11);
      check("acc_rom", 32'(dut.core.r_a), 32'h11);
      check("wrq_empty_rom", 32'(exp_wr_q.size()), 32'd0);

      // Decode edges: 07FF is RAM, 0800 and EFFF unmapped, 4000 unmapped
      reset = 1'b1;
      dut.mem.RAM[16'h7FF] = 8'h5C;
      for (int i = 16'h231; i <= 16'h233; i++) dut.mem.RAM[i] = 8'hEE;
      prog = '{8'hA9, 8'h33, 8'hAD, 8'hFF, 8'h07, 8'h8D, 8'h31, 8'h02,
               8'hAD, 8'h00, 8'h08, 8'h8D, 8'h32, 8'h02,
               8'hA9, 8'h33, 8'hAD, 8'hFF, 8'hEF, 8'h8D, 8'h33, 8'h02,
               8'hA9, 8'h33, 8'hAD, 8'h00, 8'h40, 8'h4C, 8'h1B, 8'hF0};
      load_rom(0);
      for (int i = 0; i < 2048; i++) ram_snap[i] = dut.mem.RAM[i];
      for (int i = 0; i < 4096; i++) rom_snap[i] = dut.mem.ROM[i];
      exp_wr_q.push_back('{16'h0231, 8'h5C});
      exp_wr_q.push_back('{16'h0232, 8'h00});
      exp_wr_q.push_back('{16'h0233, 8'h00});
      apply_reset(2);
      run(60);
      check("ram_top_byte", 32'(dut.mem.RAM[16'h231]), 32'h5C);
      check("unmapped_0800", 32'(dut.mem.RAM[16'h232]), 32'h00);
      check("unmapped_efff", 32'(dut.mem.RAM[16'h233]), 32'h00);
      check("acc_unmapped_4000", 32'(dut.core.r_a), 32'h00);
      n_diff = 0;
      for (int i = 0; i < 2048; i++)
         if ((i < 16'h231 || i > 16'h233) && dut.mem.RAM[i] !== ram_snap[i]) n_diff++;
      for (int i = 0; i < 4096; i++)
         if (dut.mem.ROM[i] !== rom_snap[i]) n_diff++;
      check("mem_untouched", 32'(n_diff), 32'd0);
      check("wrq_empty_dec", 32'(exp_wr_q.size()), 32'd0);

      // Reset coincident with STA 0100: LDA #66; STA 0100; JMP *
      reset = 1'b1;
      dut.mem.RAM[256] = 8'h99;
      prog = '{8'hA9, 8'h66, 8'h8D, 8'h00, 8'h01, 8'h4C, 8'h05, 8'hF0};
      load_rom(0);
      apply_reset(2);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (dut.w_core_we) begin
            found = 1'b1;
            break;
         end
         @(negedge ph1);
      end
      check("sta_reached", 32'(found), 32'd1);
      reset = 1'b1;
      run(2);
      check("rst_write_blocked", 32'(dut.mem.RAM[256]), 32'h99);
      check("rst_addr_hold", 32'(dut.w_addr), 32'hFFFC);
      exp_wr_q.push_back('{16'h0100, 8'h66});
      @(negedge ph1);
      reset = 1'b0;
      #1;
      check("restart_addr0", 32'(dut.w_addr), 32'hFFFC);
      run(1); check("restart_addr1", 32'(dut.w_addr), 32'hFFFD);
      run(1); check("restart_addr2", 32'(dut.w_addr), 32'hF000);
      run(20);
      check("restart_store", 32'(dut.mem.RAM[256]), 32'h66);
      check("wrq_empty_rst", 32'(exp_wr_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
